// File: rtl/i2c_passthru_stats.sv
// Statistics collector for the i2c passthru top: saturating event and
// master-session counters, a threshold interrupt and a synchronous read port.
module i2c_passthru_stats #(
  parameter int CNT_WIDTH  = 16,
  parameter bit CLR_ON_RD  = 1'b1,
  parameter int IRQ_THRESH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_idle_timeout,
  input  logic                 i_bit_violation,
  input  logic                 i_cha_stuck,
  input  logic                 i_chb_stuck,
  input  logic                 i_cha_ismst,
  input  logic                 i_chb_ismst,
  input  logic                 i_clr_all,
  input  logic                 i_rd_en,
  input  logic [2:0]           i_rd_addr,
  output logic [CNT_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_irq
);

  localparam logic [CNT_WIDTH-1:0] MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] MAX_M1 = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(IRQ_THRESH);

  logic [CNT_WIDTH-1:0] r_cnt [0:5];
  logic [5:0]           r_sat;
  logic                 r_cha_prev;
  logic                 r_chb_prev;

  logic [5:0]           w_ev;
  logic [5:0]           w_rdclr;
  logic [CNT_WIDTH-1:0] w_rd_mux;
  logic                 w_irq;

  always_comb begin
    w_ev = {i_chb_ismst & ~r_chb_prev, i_cha_ismst & ~r_cha_prev,
            i_chb_stuck, i_cha_stuck, i_bit_violation, i_idle_timeout};
    for (int i = 0; i < 6; i++) begin
      w_rdclr[i] = CLR_ON_RD && i_rd_en && (i_rd_addr == 3'(i));
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (i_rd_addr)
      3'd6:    w_rd_mux[7:0] = {i_chb_ismst, i_cha_ismst, r_sat};
      3'd7:    w_rd_mux = '0;
      default: w_rd_mux = r_cnt[i_rd_addr];
    endcase
  end

  // Interrupt looks at the registered counts, so it lags counter updates by one cycle.
  always_comb begin
    w_irq = 1'b0;
    if (IRQ_THRESH != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (r_cnt[i] >= THRESH) w_irq = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
      r_sat      <= '0;
      r_cha_prev <= 1'b0;
      r_chb_prev <= 1'b0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
      o_irq      <= 1'b0;
    end else begin
      r_cha_prev <= i_cha_ismst;
      r_chb_prev <= i_chb_ismst;
      o_rd_valid <= i_rd_en;
      o_irq      <= w_irq;
      if (i_rd_en) o_rd_data <= w_rd_mux;
      for (int i = 0; i < 6; i++) begin
        if (i_clr_all) begin
          r_cnt[i] <= '0;
          r_sat[i] <= 1'b0;
        end else if (w_rdclr[i]) begin
          // An event landing on the read-clear cycle starts the new count.
          r_cnt[i] <= w_ev[i] ? ONE : '0;
          r_sat[i] <= 1'b0;
        end else if (w_ev[i]) begin
          if (r_cnt[i] != MAX) r_cnt[i] <= r_cnt[i] + ONE;
          if (r_cnt[i] >= MAX_M1) r_sat[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_passthru_stats.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_i2c_passthru_stats;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;
  localparam int THR = 4;

  logic         i_clk = 1'b0;
  logic         i_rst, i_idle_timeout, i_bit_violation, i_cha_stuck, i_chb_stuck;
  logic         i_cha_ismst, i_chb_ismst, i_clr_all, i_rd_en;
  logic [2:0]   i_rd_addr;
  logic [W-1:0] o_rd_data;
  logic         o_rd_valid, o_irq;

  int total = 0;
  int bad   = 0;

  i2c_passthru_stats #(.CNT_WIDTH(W), .CLR_ON_RD(1'b1), .IRQ_THRESH(THR)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_idle_timeout(i_idle_timeout), .i_bit_violation(i_bit_violation),
    .i_cha_stuck(i_cha_stuck), .i_chb_stuck(i_chb_stuck),
    .i_cha_ismst(i_cha_ismst), .i_chb_ismst(i_chb_ismst),
    .i_clr_all(i_clr_all), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: counts as plain integers, expectations as seen after each edge.
  int m_cnt [6];
  bit m_sat [6];
  bit m_pa, m_pb;
  int exp_data;
  bit exp_valid, exp_irq, model_ok = 1'b0;

  always @(posedge i_clk) begin : mdl
    bit ev [6];
    if (i_rst) begin
      for (int i = 0; i < 6; i++) begin m_cnt[i] = 0; m_sat[i] = 0; end
      m_pa = 0; m_pb = 0;
      exp_data = 0; exp_valid = 0; exp_irq = 0;
      model_ok = 1'b1;
    end else begin
      exp_valid = i_rd_en;
      if (i_rd_en) begin
        if (i_rd_addr < 6) exp_data = m_cnt[i_rd_addr];
        else if (i_rd_addr == 6) begin
          exp_data = (int'(i_chb_ismst) << 7) + (int'(i_cha_ismst) << 6);
          for (int i = 0; i < 6; i++) exp_data += int'(m_sat[i]) << i;
        end else exp_data = 0;
      end
      exp_irq = 0;
      for (int i = 0; i < 4; i++) if (m_cnt[i] >= THR) exp_irq = 1;
      ev[0] = i_idle_timeout; ev[1] = i_bit_violation;
      ev[2] = i_cha_stuck;    ev[3] = i_chb_stuck;
      ev[4] = i_cha_ismst && !m_pa;
      ev[5] = i_chb_ismst && !m_pb;
      for (int i = 0; i < 6; i++) begin
        if (i_clr_all) begin
          m_cnt[i] = 0; m_sat[i] = 0;
        end else if (i_rd_en && i_rd_addr == 3'(i)) begin
          m_cnt[i] = ev[i] ? 1 : 0; m_sat[i] = 0;
        end else if (ev[i]) begin
          m_cnt[i] = (m_cnt[i] >= MAX) ? MAX : m_cnt[i] + 1;
          if (m_cnt[i] == MAX) m_sat[i] = 1;
        end
      end
      m_pa = i_cha_ismst; m_pb = i_chb_ismst;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (model_ok) begin
      chk("valid", int'(o_rd_valid), int'(exp_valid));
      chk("data",  int'(o_rd_data),  exp_data);
      chk("irq",   int'(o_irq),      int'(exp_irq));
    end
  end

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic rd_lit(input logic [2:0] a, input int lit, input string nm);
    step();
    i_rd_en = 1'b1; i_rd_addr = a;
    step();
    i_rd_en = 1'b0;
    chk({nm, "_valid"}, int'(o_rd_valid), 1);
    chk(nm, int'(o_rd_data), lit);
  endtask

  initial begin
    i_rst = 1'b1; i_idle_timeout = 0; i_bit_violation = 0; i_cha_stuck = 0;
    i_chb_stuck = 0; i_cha_ismst = 0; i_chb_ismst = 0; i_clr_all = 0;
    i_rd_en = 0; i_rd_addr = '0;
    repeat (3) step();
    chk("rst_valid", int'(o_rd_valid), 0);
    chk("rst_data",  int'(o_rd_data),  0);
    chk("rst_irq",   int'(o_irq),      0);
    i_rst = 1'b0;

    repeat (3) begin
      step(); i_bit_violation = 1;
      step(); i_bit_violation = 0;
    end
    rd_lit(3'd1, 3, "bitv_rd");
    rd_lit(3'd1, 0, "bitv_reread");

    step(); i_rst = 1; i_chb_ismst = 1; i_cha_ismst = 0;
    step(); i_rst = 0;
    step(); i_cha_ismst = 1;
    step(); i_cha_ismst = 0;
    step(); i_cha_ismst = 1;
    rd_lit(3'd4, 2, "cha_sess");
    rd_lit(3'd5, 1, "chb_sess");
    rd_lit(3'd6, 8'hC0, "status_ismst");

    step(); i_idle_timeout = 1;
    repeat (300) step();
    i_idle_timeout = 0;
    rd_lit(3'd6, 8'hC1, "status_sat");
    rd_lit(3'd0, 255, "idle_sat");
    rd_lit(3'd6, 8'hC0, "status_unsat");

    step(); i_cha_stuck = 1;
    repeat (5) step();
    i_rd_en = 1; i_rd_addr = 3'd2;
    step();
    i_rd_en = 0; i_cha_stuck = 0;
    chk("clr_rd_data", int'(o_rd_data), 5);
    rd_lit(3'd2, 1, "clr_rd_keep");

    step(); i_clr_all = 1;
    step(); i_clr_all = 0; i_chb_stuck = 1;
    repeat (4) step();
    i_chb_stuck = 0;
    step();
    chk("irq_rise", int'(o_irq), 1);
    i_clr_all = 1; i_chb_stuck = 1;
    step();
    i_clr_all = 0; i_chb_stuck = 0;
    chk("irq_lag", int'(o_irq), 1);
    step();
    chk("irq_fall", int'(o_irq), 0);
    rd_lit(3'd3, 0, "clr_discard");

    step(); i_idle_timeout = 1;
    repeat (7) step();
    i_idle_timeout = 0; i_rd_en = 1; i_rd_addr = 3'd0; i_rst = 1;
    step();
    i_rd_en = 0; i_rst = 0;
    chk("rstrd_valid", int'(o_rd_valid), 0);
    chk("rstrd_data",  int'(o_rd_data),  0);
    rd_lit(3'd0, 0, "rstrd_cnt");

    for (int n = 0; n < 6000; n++) begin
      bit busy;
      busy = (n >= 3000);
      step();
      i_rst           = ($urandom_range(0, 799) == 0);
      i_clr_all       = ($urandom_range(0, 299) == 0);
      i_idle_timeout  = busy ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
      i_bit_violation = ($urandom_range(0, 7) == 0);
      i_cha_stuck     = busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      i_chb_stuck     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) i_cha_ismst = ~i_cha_ismst;
      if ($urandom_range(0, 9) == 0) i_chb_ismst = ~i_chb_ismst;
      i_rd_en   = busy ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 2) == 0);
      i_rd_addr = 3'($urandom_range(0, 7));
    end
    step();
    i_rst = 0; i_clr_all = 0; i_rd_en = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_passthru_stats.md
Name: i2c_passthru_stats

Overview:
Event/statistics collector sitting directly downstream of the i2c passthru top. Consumes its single-cycle status pulses (idle timeout, bit violation, per-channel stuck) and its master-indication levels. Keeps saturating event counters and master-session counters, plus a threshold interrupt, all readable through a simple synchronous read port. The block is purely observational and never drives the I2C buses.

Parameters:
CNT_WIDTH, 16, width of every counter and of o_rd_data; must be >= 8.
CLR_ON_RD, 1, 1 = a read of counters 0-5 clears the addressed counter; 0 = counters clear only via i_clr_all.
IRQ_THRESH, 4, error-counter value (addr 0-3) at or above which o_irq asserts; 0 disables o_irq.

Ports:
i_clk  in  1  system clock, same clock as passthru top.
i_rst  in  1  synchronous reset, active high.
i_idle_timeout  in  1  single-cycle pulse, bus went idle by timeout.
i_bit_violation  in  1  single-cycle pulse, bit violation.
i_cha_stuck  in  1  single-cycle pulse, channel a stuck.
i_chb_stuck  in  1  single-cycle pulse, channel b stuck.
i_cha_ismst  in  1  level, channel a currently master.
i_chb_ismst  in  1  level, channel b currently master.
i_clr_all  in  1  synchronous clear of all counters and sticky flags.
i_rd_en  in  1  read strobe.
i_rd_addr  in  3  read address.
o_rd_data  out  CNT_WIDTH  read data, valid when o_rd_valid is high.
o_rd_valid  out  1  one-cycle pulse, one cycle after i_rd_en.
o_irq  out  1  level interrupt, registered.

Behaviour:
- One clock (i_clk); reset is synchronous, active high (i_rst). On reset: all counters 0, sticky flags 0, ismst edge registers 0, o_rd_data 0, o_rd_valid 0, o_irq 0.
- Counter map: 0 idle_timeout, 1 bit_violation, 2 cha_stuck, 3 chb_stuck, 4 cha master sessions, 5 chb master sessions.
- Addr 6 is the status word: bits[5:0] are the sticky saturation flags for counters 0-5; bit6 = i_cha_ismst; bit7 = i_chb_ismst (both sampled the cycle of i_rd_en); the upper bits are 0.
- Addr 7 reads 0.
- Counters 0-3 increment by 1 on each cycle their input pulse is high. A pulse held high N cycles counts N.
- Counters 4/5 increment on rising edges of i_cha_ismst/i_chb_ismst, detected against a registered previous value. That register resets to 0, so a level that is high in the first cycle after reset counts as one session.
- Saturation: at all-ones a counter holds and its sticky flag sets. The flag stays set until that counter is cleared.
- Read timing: i_rd_en at cycle T gives o_rd_data and o_rd_valid=1 at T+1. The value returned is the counter as it stood before any increment at T. o_rd_data holds its last value when o_rd_valid is low.
- Clear-on-read (CLR_ON_RD=1, addr 0-5): the counter and its sticky flag clear at T.
  - Event coincident with the read-clear: the counter becomes 1 and the event is not lost. The flag is cleared.
  - Reading addr 6 or 7 clears nothing.
- i_clr_all: all counters and flags go to 0 next cycle.
  - Events coincident with i_clr_all are discarded; clear has priority.
  - i_rd_en in the same cycle still returns the pre-clear value.
- o_irq is registered: high when any of counters 0-3 >= IRQ_THRESH, low otherwise. It tracks clears with one cycle lag; it is never sticky by itself.
- Reset mid-read: i_rst at T with i_rd_en at T gives o_rd_valid=0 at T+1.
- Both ismst inputs rising in the same cycle: both counters increment. No arbitration check is made in this block.

Test Plan:
- Reset, then pulse i_bit_violation 3 single cycles; read addr 1 -> o_rd_data=3 at T+1, o_rd_valid=1; re-read -> 0 (CLR_ON_RD=1).
- Toggle i_cha_ismst 0->1->0->1 and hold i_chb_ismst high from the first cycle after reset; read addr 4 -> 2, addr 5 -> 1, addr 6 -> bit6=1, bit7=1.
- CNT_WIDTH=8: 300 i_idle_timeout pulses; read addr 6 -> bit0=1; read addr 0 -> 255; read addr 6 again -> bit0=0.
- i_cha_stuck pulse in the same cycle as a clear-on-read of addr 2 holding 5 -> returns 5, next read -> 1.
- IRQ_THRESH=4: 4 i_chb_stuck pulses -> o_irq rises the cycle after the 4th; i_clr_all with a coincident pulse -> all counters 0, o_irq low one cycle later.
- i_rst asserted in the same cycle as i_rd_en on addr 0 holding 7 -> o_rd_valid=0, o_rd_data=0, counter 0 = 0.
